// File: rtl/dram_fifo64.sv
// rtl/dram_fifo64.sv - 64-deep synchronous FIFO on distributed LUT RAM
//
// Purpose: a small elastic buffer. The storage array has a synchronous write
// port and an asynchronous read port. The read side registers the word at
// rd_ptr when a pop is accepted, so RD_DATA arrives one clock after RD_EN.
//
// Ports:
//   CLK        clock; all state updates on the rising edge
//   RST_N      asynchronous active-low reset (release synchronous to CLK)
//   WR_EN      push request
//   WR_DATA    push data, WIDTH bits
//   FULL       registered; high when 64 words are held
//   RD_EN      pop request
//   RD_DATA    popped word, registered; holds its value between pops
//   RD_VALID   one-cycle pulse per accepted pop
//   EMPTY      registered; high when 0 words are held
//   LEVEL      occupancy 0..64, DEPTH_LOG2+1 bits
//   OVERFLOW   one-cycle pulse after a push requested while FULL
//   UNDERFLOW  one-cycle pulse after a pop requested while EMPTY
//
// DEPTH_LOG2 is meant to stay at 6 so the array maps onto 64-deep LUT RAM.

module dram_fifo64 #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_EN,
  input  logic [WIDTH-1:0]      WR_DATA,
  output logic                  FULL,
  input  logic                  RD_EN,
  output logic [WIDTH-1:0]      RD_DATA,
  output logic                  RD_VALID,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = DEPTH[DEPTH_LOG2:0];

  // Storage is never reset, matching LUT-RAM behaviour.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  push_ok;
  logic                  pop_ok;

  // Acceptance uses the registered flags only. Because of that, a push and a
  // pop can never target the same slot in one cycle: equal pointers mean
  // LEVEL is 0 or 64, and either value blocks one of the two sides.
  assign push_ok = WR_EN & ~FULL;
  assign pop_ok  = RD_EN & ~EMPTY;

  always_comb begin
    level_next = LEVEL;
    if (push_ok && !pop_ok) begin
      level_next = LEVEL + LEVEL_ONE;
    end else if (pop_ok && !push_ok) begin
      level_next = LEVEL - LEVEL_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      LEVEL     <= '0;
      EMPTY     <= 1'b1;
      FULL      <= 1'b0;
      RD_DATA   <= '0;
      RD_VALID  <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        RD_DATA <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      RD_VALID  <= pop_ok;
      LEVEL     <= level_next;
      EMPTY     <= (level_next == '0);
      FULL      <= (level_next == LEVEL_MAX);
      OVERFLOW  <= WR_EN & FULL;
      UNDERFLOW <= RD_EN & EMPTY;
    end
  end

endmodule

// File: tb/tb_dram_fifo64.sv
// tb/tb_dram_fifo64.sv - directed self-checking bench for dram_fifo64

module tb_dram_fifo64;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_EN = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       FULL;
  logic       RD_EN = 1'b0;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       EMPTY;
  logic [6:0] LEVEL;
  logic       OVERFLOW;
  logic       UNDERFLOW;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [7:0] last_rd = 8'h00;

  dram_fifo64 #(.WIDTH(8), .DEPTH_LOG2(6)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .WR_EN(WR_EN),
    .WR_DATA(WR_DATA),
    .FULL(FULL),
    .RD_EN(RD_EN),
    .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID),
    .EMPTY(EMPTY),
    .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, checked against the queue model of the FIFO.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
    logic push_ok;
    logic pop_ok;
    logic exp_ov;
    logic exp_un;
    push_ok = we && (q.size() < 64);
    pop_ok  = re && (q.size() != 0);
    exp_ov  = we && (q.size() == 64);
    exp_un  = re && (q.size() == 0);
    if (pop_ok) last_rd = q.pop_front();
    if (push_ok) q.push_back(wd);
    WR_EN = we;
    WR_DATA = wd;
    RD_EN = re;
    tick();
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    chk("rd_valid", RD_VALID, pop_ok);
    chk("rd_data", RD_DATA, last_rd);
    chk("level", LEVEL, q.size());
    chk("overflow", OVERFLOW, exp_ov);
    chk("underflow", UNDERFLOW, exp_un);
    chk("full", FULL, q.size() == 64);
    chk("empty", EMPTY, q.size() == 0);
  endtask

  initial begin
    // Reset then idle
    RST_N = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_underflow", UNDERFLOW, 0);
    RST_N = 1'b1;
    tick();

    cyc(1'b0, 8'h00, 1'b1);
    chk("idle_underflow", UNDERFLOW, 1);
    chk("idle_level", LEVEL, 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_underflow_clear", UNDERFLOW, 0);

    // Fill 0x00..0x3F then drain in order
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("fill_full", FULL, 1);
    chk("fill_level", LEVEL, 64);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_word", RD_DATA, i);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("drain_empty", EMPTY, 1);
    chk("drain_hold", RD_DATA, 8'h3F);
    chk("drain_valid_low", RD_VALID, 0);

    // Overflow and write-pointer wrap
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", OVERFLOW, 1);
    chk("ovf_level", LEVEL, 64);
    cyc(1'b0, 8'h00, 1'b1);
    chk("ovf_pop0", RD_DATA, 8'h00);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("wrap_full", FULL, 1);
    for (int i = 1; i < 64; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("wrap_word", RD_DATA, i);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("wrap_last", RD_DATA, 8'hAA);
    chk("wrap_empty", EMPTY, 1);

    // Simultaneous push/pop at LEVEL 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 8'h20 + 8'(k), 1'b1);
      chk("sim_level", LEVEL, 5);
    end
    chk("sim_last_word", RD_DATA, 8'h24);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("sim_drain_last", RD_DATA, 8'h29);

    // Both high while EMPTY: push only
    cyc(1'b1, 8'h77, 1'b1);
    chk("emp_both_level", LEVEL, 1);
    chk("emp_both_underflow", UNDERFLOW, 1);
    chk("emp_both_valid", RD_VALID, 0);

    // Both high while FULL: pop only
    for (int i = 0; i < 63; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0);
    chk("pre_full", FULL, 1);
    cyc(1'b1, 8'h99, 1'b1);
    chk("full_both_level", LEVEL, 63);
    chk("full_both_overflow", OVERFLOW, 1);
    chk("full_both_data", RD_DATA, 8'h77);

    // Async reset mid-stream at LEVEL 20, just after a pop
    for (int i = 0; i < 43; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("mid_level", LEVEL, 20);
    chk("mid_valid", RD_VALID, 1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("arst_valid", RD_VALID, 0);
    chk("arst_level", LEVEL, 0);
    chk("arst_empty", EMPTY, 1);
    chk("arst_full", FULL, 0);
    chk("arst_rd_data", RD_DATA, 0);
    q.delete();
    last_rd = 8'h00;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_data", RD_DATA, 8'h5A);
    chk("post_rst_valid", RD_VALID, 1);
    chk("post_rst_empty", EMPTY, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
